// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter.
// Latches a PAT_BITS-wide pattern on a start request and shifts it out
// MSB-first, one bit per clock. The pattern is repeated `reps` times, and
// `gap` idle bits are inserted between repetitions.
//
// Ports:
//   clk      system clock, rising edge
//   n_rst    asynchronous active-low reset
//   start    transmit request, accepted only while busy=0
//   pattern  pattern to send (MSB first), latched at accept
//   reps     repetition count, latched at accept (0 = empty transfer)
//   gap      idle bits between repetitions, latched at accept
//   o        registered serial output
//   busy     registered, high while a transfer is in progress
//   done     registered one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start; o = IDLE_VALUE
// SHIFT  | driving pattern bits, o = pat_q[bit_q]
// GAP    | inter-repetition idle bits, o = IDLE_VALUE
module pattern_tx #(
  parameter int   PAT_BITS   = 4,
  parameter int   CNT_BITS   = 4,
  parameter logic IDLE_VALUE = 1'b0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [PAT_BITS-1:0] pattern,
  input  logic [CNT_BITS-1:0] reps,
  input  logic [CNT_BITS-1:0] gap,
  output logic                o,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = (PAT_BITS > 1) ? $clog2(PAT_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PAT_BITS-1:0] pat_q, pat_d;
  logic [CNT_BITS-1:0] rep_q, rep_d;
  logic [CNT_BITS-1:0] gap_len_q, gap_len_d;
  logic [CNT_BITS-1:0] gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]    bit_q, bit_d;
  logic                o_q, o_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [IDX_W-1:0]    bit_dec;
  logic [CNT_BITS-1:0] rep_rem;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    bit_d     = bit_q;
    o_d       = o_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_dec   = bit_q - IDX_W'(1);
    rep_rem   = rep_q - CNT_BITS'(1);

    case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          pat_d     = pattern;
          rep_d     = reps;
          gap_len_d = gap;
          if (reps == '0) begin
            // Empty transfer: completes without ever raising busy.
            done_d = 1'b1;
          end else begin
            state_d = S_SHIFT;
            o_d     = pattern[PAT_BITS-1];
            busy_d  = 1'b1;
            bit_d   = IDX_MSB;
          end
        end
      end

      S_SHIFT: begin
        if (bit_q != '0) begin
          bit_d = bit_dec;
          o_d   = pat_q[bit_dec];
        end else begin
          // Bit 0 has been on the line for one cycle: repetition complete.
          rep_d = rep_rem;
          if (rep_rem == '0) begin
            state_d = S_IDLE;
            o_d     = IDLE_VALUE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (gap_len_q != '0) begin
            state_d   = S_GAP;
            o_d       = IDLE_VALUE;
            gap_cnt_d = gap_len_q;
          end else begin
            bit_d = IDX_MSB;
            o_d   = pat_q[PAT_BITS-1];
          end
        end
      end

      S_GAP: begin
        // gap_cnt_q counts the idle cycles still to be shown, including this one.
        if (gap_cnt_q == CNT_BITS'(1)) begin
          state_d = S_SHIFT;
          bit_d   = IDX_MSB;
          o_d     = pat_q[PAT_BITS-1];
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_BITS'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        o_d     = IDLE_VALUE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      bit_q     <= '0;
      o_q       <= IDLE_VALUE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      bit_q     <= bit_d;
      o_q       <= o_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o    = o_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
